bist_ctrl: RTL and testbench
============================

BIST_CTRL -- requirements
Module: bist_ctrl

Interface
REQ-001 The block SHALL have parameter NPAT, default 1024, meaning the number of pattern cycles per BIST run; legal range 1..65535.
REQ-002 The block SHALL have parameter NBIT, default 16, meaning the signature width.
REQ-003 The block SHALL have parameter GOLDEN, default 16'hFFFF, meaning the expected fault-free signature.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: run request, sampled only in IDLE or DONE.
REQ-007 The block SHALL have port signature, input, NBIT bits: the MISR contents.
REQ-008 The block SHALL have port misr_rst, output, 1 bit: seed request for the MISR and LFSR.
REQ-009 The block SHALL have port cut_rst, output, 1 bit: reset for the arbiter under test.
REQ-010 The block SHALL have port pat_en, output, 1 bit: advance the pattern LFSR driving the arbiter requests.
REQ-011 The block SHALL have port finish, output, 1 bit: freeze the MISR.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: high when the result is valid.
REQ-014 The block SHALL have port pass, output, 1 bit: comparison result, meaningful only while done=1.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, INIT, RUN, FLUSH, CMP, DONE.
REQ-016 IDLE: start=1 SHALL transition to INIT; otherwise the FSM SHALL stay in IDLE.
REQ-017 INIT SHALL last exactly one cycle with misr_rst=1, cut_rst=1, pat_en=0, finish=0, and SHALL load the pattern counter with NPAT-1.
REQ-018 RUN SHALL last exactly NPAT cycles with pat_en=1 and finish=0, decrementing the counter each cycle and leaving RUN when the counter equals 0.
REQ-019 FLUSH SHALL last exactly one cycle with pat_en=0 and finish=0, so the MISR absorbs the registered grant of the last pattern.
REQ-020 CMP SHALL last exactly one cycle with finish=1, and SHALL register pass = (signature == GOLDEN) at the end of that cycle.
REQ-021 DONE SHALL assert done=1 and finish=1 and hold pass stable; start=1 SHALL go to INIT (re-run) and SHALL clear done in the same edge.
REQ-022 busy SHALL be 1 in INIT, RUN, FLUSH and CMP, and 0 in IDLE and DONE.
REQ-023 busy SHALL be high for exactly NPAT+3 consecutive cycles per run.
REQ-024 start SHALL be ignored in INIT, RUN, FLUSH and CMP, with no queuing.
REQ-025 finish SHALL be 1 in IDLE, CMP and DONE, so the MISR never integrates when idle.
REQ-026 misr_rst and cut_rst SHALL be 0 in every state except INIT.
REQ-027 The counter width SHALL be clog2(NPAT+1) bits, SHALL never wrap below 0, and NPAT=1 SHALL give a single RUN cycle.
REQ-028 All outputs SHALL be registered or decoded from the state register only; there SHALL be no combinational path from start to any output.

Reset
REQ-029 On rst=1, at the next edge, the block SHALL enter state IDLE, clear the counter to 0, and set misr_rst=0, cut_rst=0, pat_en=0, finish=1, busy=0, done=0, pass=0.
REQ-030 rst SHALL override start and any state, including mid-RUN; no partial result SHALL be reported and done SHALL stay 0.

Structure
REQ-031 A shared package bist_pkg SHALL hold the state enum (bist_state_t), the default NBIT and GOLDEN constants, and a clog2-based counter-width function.
REQ-032 One sub-module SHALL be used: bist_cnt, a loadable down-counter with a zero flag; the FSM and comparator SHALL be in bist_ctrl.

Verification
REQ-033 NPAT=4, GOLDEN=16'h1234, stub signature=16'h1234: pulse start -> INIT 1 cycle with misr_rst=cut_rst=1, pat_en high exactly 4 cycles, then FLUSH 1 cycle, then CMP 1 cycle, then done=1 and pass=1; busy high for 7 cycles.
REQ-034 Same configuration with signature=16'h1235 -> done=1, pass=0.
REQ-035 Pulse start again during the 2nd RUN cycle -> no effect; pat_en count stays 4 and done rises on the same cycle as in the undisturbed run.
REQ-036 Assert rst during the 3rd RUN cycle -> next cycle all outputs match REQ-029, state is IDLE, done never asserts.
REQ-037 From DONE with pass=1, change signature to 16'h0000 and pulse start -> done drops at the next edge, a full re-run occurs, and the new result is pass=0.
REQ-038 NPAT=1 -> pat_en high for exactly 1 cycle and busy high for exactly 4 cycles.

Source files
------------

// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state type, defaults and counter sizing for the BIST controller
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    CMP   = 3'd4,
    DONE  = 3'd5
  } bist_state_t;

  localparam int                  NBIT_DEF   = 16;
  localparam logic [NBIT_DEF-1:0] GOLDEN_DEF = 16'hFFFF;

  // Enough bits to hold any count 0..npat.
  function automatic int cnt_width(input int npat);
    return $clog2(npat + 1);
  endfunction

endpackage

// File: rtl/bist_cnt.sv
// rtl/bist_cnt.sv - loadable down-counter with zero flag, saturating at 0
module bist_cnt #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority over decrement; decrement stops at 0 so the count never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bist_ctrl.sv
// rtl/bist_ctrl.sv - BIST sequencer: seeds MISR, runs NPAT patterns, compares signature
module bist_ctrl
  import bist_pkg::*;
#(
  parameter int              NPAT   = 1024,
  parameter int              NBIT   = NBIT_DEF,
  parameter logic [NBIT-1:0] GOLDEN = NBIT'(GOLDEN_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NBIT-1:0] signature,
  output logic            misr_rst,
  output logic            cut_rst,
  output logic            pat_en,
  output logic            finish,
  output logic            busy,
  output logic            done,
  output logic            pass
);

  localparam int            CW       = cnt_width(NPAT);
  localparam logic [CW-1:0] LOAD_VAL = CW'(NPAT - 1);

  bist_state_t state, state_nx;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;

  bist_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LOAD_VAL),
    .zero     (cnt_zero)
  );

  // State register; reset wins over everything, including a run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and state-decoded outputs; start is only looked at in IDLE and DONE.
  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    misr_rst = 1'b0;
    cut_rst  = 1'b0;
    pat_en   = 1'b0;
    finish   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        finish = 1'b1;
        if (start) state_nx = INIT;
      end
      INIT: begin
        misr_rst = 1'b1;
        cut_rst  = 1'b1;
        busy     = 1'b1;
        cnt_load = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        pat_en  = 1'b1;
        busy    = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_zero) state_nx = FLUSH;
      end
      FLUSH: begin
        busy     = 1'b1;
        state_nx = CMP;
      end
      CMP: begin
        finish   = 1'b1;
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        finish = 1'b1;
        done   = 1'b1;
        if (start) state_nx = INIT;
      end
      default: begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  // Result register: captured at the end of CMP, held through DONE until the next CMP.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass <= 1'b0;
    end else if (state == CMP) begin
      pass <= (signature == GOLDEN);
    end
  end

endmodule

// File: tb/tb_bist_ctrl.sv
// tb/tb_bist_ctrl.sv - scoreboard bench for bist_ctrl with NPAT=4 and NPAT=1 instances
module tb_bist_ctrl;

  localparam logic [15:0] GOLD = 16'h1234;
  localparam int NP0 = 4;
  localparam int NP1 = 1;

  typedef struct {
    int   inst;
    int   npat;
    logic pass;
  } exp_t;

  logic        clk;
  logic        rst       [2];
  logic        start     [2];
  logic [15:0] signature [2];
  logic        misr_rst  [2];
  logic        cut_rst   [2];
  logic        pat_en    [2];
  logic        finish    [2];
  logic        busy      [2];
  logic        done      [2];
  logic        pass      [2];

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  bist_ctrl #(.NPAT(NP0), .NBIT(16), .GOLDEN(GOLD)) u_dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .signature(signature[0]),
    .misr_rst(misr_rst[0]), .cut_rst(cut_rst[0]), .pat_en(pat_en[0]),
    .finish(finish[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0])
  );

  bist_ctrl #(.NPAT(NP1), .NBIT(16), .GOLDEN(GOLD)) u_dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .signature(signature[1]),
    .misr_rst(misr_rst[1]), .cut_rst(cut_rst[1]), .pat_en(pat_en[1]),
    .finish(finish[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int npat_of(input int k);
    return (k == 0) ? NP0 : NP1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input int k);
    chk($sformatf("rst_misr_rst%0d", k), int'(misr_rst[k]), 0);
    chk($sformatf("rst_cut_rst%0d", k),  int'(cut_rst[k]),  0);
    chk($sformatf("rst_pat_en%0d", k),   int'(pat_en[k]),   0);
    chk($sformatf("rst_finish%0d", k),   int'(finish[k]),   1);
    chk($sformatf("rst_busy%0d", k),     int'(busy[k]),     0);
    chk($sformatf("rst_done%0d", k),     int'(done[k]),     0);
    chk($sformatf("rst_pass%0d", k),     int'(pass[k]),     0);
  endtask

  // Monitor: accumulates per-run activity and checks it against the scoreboard when done rises.
  int   busy_cnt [2];
  int   pat_cnt  [2];
  int   init_cnt [2];
  logic prev_busy [2];
  logic prev_done [2];
  logic prev_pass [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      busy_cnt[k] = 0; pat_cnt[k] = 0; init_cnt[k] = 0;
      prev_busy[k] = 1'b0; prev_done[k] = 1'b0; prev_pass[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst[k]) begin
          busy_cnt[k] = 0; pat_cnt[k] = 0; init_cnt[k] = 0;
          prev_busy[k] = 1'b0; prev_done[k] = 1'b0; prev_pass[k] = 1'b0;
        end else begin
          logic inv_ok;
          inv_ok = (misr_rst[k] == cut_rst[k]) &&
                   (!done[k] || (finish[k] && !busy[k])) &&
                   (!pat_en[k] || (busy[k] && !finish[k])) &&
                   (!misr_rst[k] || (busy[k] && !finish[k] && !pat_en[k])) &&
                   (finish[k] || busy[k]);
          chk($sformatf("invariant%0d", k), int'(inv_ok), 1);
          if (busy[k] && !prev_busy[k]) begin
            busy_cnt[k] = 0; pat_cnt[k] = 0; init_cnt[k] = 0;
          end
          if (busy[k]) begin
            busy_cnt[k]++;
            if (pat_en[k])   pat_cnt[k]++;
            if (misr_rst[k]) init_cnt[k]++;
          end
          if (done[k] && prev_done[k])
            chk($sformatf("pass_stable%0d", k), int'(pass[k]), int'(prev_pass[k]));
          if (done[k] && !prev_done[k]) begin
            if (sb.size() == 0) begin
              chk($sformatf("unexpected_done%0d", k), 1, 0);
            end else begin
              exp_t e;
              e = sb.pop_front();
              chk("sb_inst", k, e.inst);
              chk($sformatf("busy_len%0d", k), busy_cnt[k], e.npat + 3);
              chk($sformatf("pat_en_len%0d", k), pat_cnt[k], e.npat);
              chk($sformatf("init_len%0d", k), init_cnt[k], 1);
              chk($sformatf("done_after_busy%0d", k), int'(prev_busy[k]), 1);
              chk($sformatf("pass%0d", k), int'(pass[k]), int'(e.pass));
            end
          end
          prev_busy[k] = busy[k];
          prev_done[k] = done[k];
          prev_pass[k] = pass[k];
        end
      end
    end
  end

  // One run on instance k; disturb_at/abort_at are busy-cycle indices (INIT=0), 0 means none.
  task automatic do_run(input int k, input logic [15:0] sig, input int disturb_at, input int abort_at);
    int np;
    np = npat_of(k);
    @(posedge clk); #1;
    signature[k] = sig;
    start[k] = 1'b1;
    if (abort_at == 0) sb.push_back('{inst: k, npat: np, pass: (sig == GOLD)});
    @(posedge clk); #1;
    start[k] = 1'b0;
    chk($sformatf("init_busy%0d", k), int'(busy[k]), 1);
    chk($sformatf("init_done%0d", k), int'(done[k]), 0);
    chk($sformatf("init_misr%0d", k), int'(misr_rst[k]), 1);
    chk($sformatf("init_pat_en%0d", k), int'(pat_en[k]), 0);
    for (int c = 1; c <= np + 2; c++) begin
      @(posedge clk); #1;
      start[k] = (c == disturb_at);
      if (c == abort_at) begin
        rst[k] = 1'b1;
        @(posedge clk); #1;
        rst[k] = 1'b0;
        start[k] = 1'b0;
        chk_reset(k);
        for (int w = 0; w < np + 6; w++) begin
          @(posedge clk); #1;
          chk($sformatf("abort_no_done%0d", k), int'(done[k]), 0);
        end
        return;
      end
    end
    @(posedge clk); #1;
    start[k] = 1'b0;
    chk($sformatf("done_at_n_plus_3_%0d", k), int'(done[k]), 1);
    chk($sformatf("done_busy%0d", k), int'(busy[k]), 0);
    chk($sformatf("done_finish%0d", k), int'(finish[k]), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; signature[k] = 16'h0000;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    // start held high under reset must not leak through
    start[0] = 1'b1;
    @(posedge clk); #1;
    chk_reset(0);
    start[0] = 1'b0;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    do_run(0, GOLD, 0, 0);
    do_run(0, 16'h1235, 0, 0);
    do_run(0, GOLD, 2, 0);
    do_run(0, GOLD, 0, 3);
    do_run(0, GOLD, 0, 0);
    do_run(0, 16'h0000, 0, 0);
    do_run(1, GOLD, 0, 0);
    do_run(1, 16'h0001, 1, 0);
    do_run(1, GOLD, 3, 0);

    for (int i = 0; i < 40; i++) begin
      int k, np, dis, ab;
      logic [15:0] s;
      k   = int'($urandom_range(0, 1));
      np  = npat_of(k);
      s   = ($urandom_range(0, 1) == 1) ? GOLD : 16'($urandom);
      dis = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, np + 2)) : 0;
      ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, np + 2)) : 0;
      do_run(k, s, dis, ab);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
